spi_servo_cmd_decoder: RTL and testbench
========================================

// Module: spi_servo_cmd_decoder
// PURPOSE
//  Decodes framed SPI byte streams from spi_slave (done/dout/frame_start/frame_end) into servo position commands.
//  Successor to the fixed 64-ch/8-bit decoder: adds parametrised channel count and position width,
//  multi-byte MSB-first words, burst and broadcast writes, range clamping and error reporting.
//  Sits between spi_slave and the servo PWM bank; drives the servo_num/servo_pos/new_pos bus.
// PARAMETERS
//  NUM_CH     32            number of servo channels; ADDR_W = max(1,$clog2(NUM_CH)) is a derived localparam
//  POS_W      12            position width, 1..16; POS_BYTES = (POS_W+7)/8 is a derived localparam
//  POS_MAX    2**POS_W-1    upper clamp for received positions
//  ERR_CNT_W  8             width of saturating error counter
// PORTS
//  clk          in   1          system clock
//  rst_n        in   1          synchronous active-low reset
//  spi_done     in   1          one-cycle strobe: spi_dout holds a received byte
//  spi_dout     in   8          received byte
//  frame_start  in   1          one-cycle strobe: SS asserted
//  frame_end    in   1          one-cycle strobe: SS released
//  servo_num    out  ADDR_W     channel of committed word (0 when servo_all)
//  servo_pos    out  POS_W      committed, clamped position
//  servo_all    out  1          committed word applies to all channels; valid with new_pos
//  new_pos      out  1          one-cycle commit strobe
//  frame_err    out  1          one-cycle error strobe
//  err_count    out  ERR_CNT_W  saturating count of frame_err pulses
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state IDLE; all outputs 0; err_count 0; any partial word discarded.
//  Header byte: [7:6] cmd, [5:0] start address. cmd 00 SINGLE, 01 BURST, 10 BCAST, 11 reserved.
//  Word: POS_BYTES bytes MSB first; raw value = low POS_W bits of the concatenation; nonzero bits above POS_W -> treated as > POS_MAX.
//  Clamp: servo_pos = (raw > POS_MAX) ? POS_MAX : raw.
//  States: IDLE -frame_start-> HDR; HDR -spi_done-> POS (cmd 00/01/10) or DISCARD (cmd 11: frame_err).
//   POS collects POS_BYTES bytes; on last byte -> commit (or CHK if checksum compiled in).
//   After commit: SINGLE/BCAST -> DISCARD (extra bytes ignored, no error); BURST -> addr+1, stay POS.
//   DISCARD ignores bytes until frame_end. frame_end in any state -> IDLE; frame_start in any state -> HDR (restart).
//  Commit: new_pos=1 exactly one cycle after the spi_done of the word's final byte; servo_num/servo_pos/servo_all held until next commit.
//  Address >= NUM_CH at header or after burst increment (incl. 63 -> wrap): word dropped, frame_err, -> DISCARD. No wrap-around.
//  spi_done and frame_end in the same cycle: byte processed first (may commit), then IDLE.
//  frame_end with partial word (1..POS_BYTES-1 bytes, or header only) -> frame_err, no commit. Empty frame (no bytes) -> no error.
//  frame_err also registered: one cycle after triggering spi_done/frame_end. err_count increments per pulse, saturates at all-ones.
// CONFIGURATION
//  SPI_SERVO_CHECKSUM_EN defined: each word followed by a check byte; XOR(header, word bytes, check) must be 8'h00.
//   Match -> commit one cycle after check byte's spi_done. Mismatch -> frame_err, no commit, -> DISCARD.
//   frame_end before check byte -> partial-word error.
//  Not defined: no check byte; commit directly after the final position byte.
// STRUCTURE
//  Package spi_servo_pkg: cmd codes (CMD_SINGLE/BURST/BCAST/RSVD), state enum (IDLE,HDR,POS,CHK,DISCARD), header field positions.
//  Flat module: byte counter, POS_BYTES*8 shift register, address register, checksum accumulator, registered outputs.
//  No sub-module; clamp is inline combinational logic.
// TESTING
//  SINGLE hdr 8'h05, bytes 8'h01,8'h23 -> one new_pos, servo_num=5, servo_pos=12'h123, servo_all=0, frame_err=0.
//  BURST hdr 8'h5E, three words 0x0100,0x0FFF,0x1234 -> commits ch30=0x100, ch31=0xFFF; 3rd word: frame_err, err_count=1.
//  BCAST hdr 8'h80, word 0x0ABC -> new_pos with servo_all=1, servo_num=0, servo_pos=0xABC; trailing bytes ignored.
//  POS_MAX=2000: SINGLE ch2, word 0x0FA0 -> servo_pos=2000; hdr 8'hC0 -> frame_err, no new_pos until next frame.
//  frame_end after one position byte -> frame_err, no commit; rst_n low mid-word -> outputs 0, next frame decodes normally.
//  CHECKSUM_EN: hdr 8'h03, 8'h01,8'h23, chk 8'h21 -> commit ch3=0x123; chk 8'h20 -> frame_err, no commit.

Source files
------------

// File: rtl/spi_servo_cmd_decoder_pkg.sv
// Shared definitions for the SPI servo command decoder.
// Holds the header command codes, the decoder state encoding, the header
// field positions and the running-XOR helper used by the optional check byte.
package spi_servo_pkg;

    typedef enum logic [1:0] {
        CMD_SINGLE = 2'b00,
        CMD_BURST  = 2'b01,
        CMD_BCAST  = 2'b10,
        CMD_RSVD   = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR     = 3'd1,
        POS     = 3'd2,
        CHK     = 3'd3,
        DISCARD = 3'd4
    } state_e;

    // Header byte layout: [7:6] command, [5:0] start address
    localparam int HDR_CMD_MSB  = 7;
    localparam int HDR_CMD_LSB  = 6;
    localparam int HDR_ADDR_MSB = 5;
    localparam int HDR_ADDR_LSB = 0;

    // Running XOR of a frame's header, word and check bytes
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/spi_servo_cmd_decoder_if.sv
// Bus between spi_slave / servo PWM bank and the command decoder.
// SPI side : spi_done, spi_dout, frame_start, frame_end (byte stream strobes)
// Servo side: servo_num, servo_pos, servo_all, new_pos, frame_err, err_count
// modport slave  - used by the decoder (consumes bytes, drives servo bus)
// modport master - used by whoever feeds bytes and watches the servo bus
interface spi_servo_cmd_decoder_if #(
    parameter int ADDR_W    = 5,
    parameter int POS_W     = 12,
    parameter int ERR_CNT_W = 8
);
    logic                 spi_done;
    logic [7:0]           spi_dout;
    logic                 frame_start;
    logic                 frame_end;
    logic [ADDR_W-1:0]    servo_num;
    logic [POS_W-1:0]     servo_pos;
    logic                 servo_all;
    logic                 new_pos;
    logic                 frame_err;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output spi_done, spi_dout, frame_start, frame_end,
        input  servo_num, servo_pos, servo_all, new_pos, frame_err, err_count
    );

    modport slave (
        input  spi_done, spi_dout, frame_start, frame_end,
        output servo_num, servo_pos, servo_all, new_pos, frame_err, err_count
    );
endinterface

// File: rtl/spi_servo_cmd_decoder.sv
// Decodes framed SPI byte streams into servo position commands.
// Frame: header byte ([7:6] cmd, [5:0] start addr) followed by MSB-first
// position words of POS_BYTES bytes. SINGLE/BCAST commit one word, BURST
// commits consecutive channels. Positions are clamped to POS_MAX.
// Ports:
//   clk   - system clock
//   rst_n - synchronous active-low reset
//   bus   - spi_servo_cmd_decoder_if.slave (SPI strobes in, servo bus out)
// Optional feature: define SPI_SERVO_CHECKSUM_EN to require a check byte after
// every word; XOR of header, word bytes and check byte must be zero.
module spi_servo_cmd_decoder
    import spi_servo_pkg::*;
#(
    parameter int NUM_CH    = 32,
    parameter int POS_W     = 12,
    parameter int POS_MAX   = 2**POS_W - 1,
    parameter int ERR_CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    spi_servo_cmd_decoder_if.slave  bus
);
    localparam int ADDR_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int POS_BYTES = (POS_W + 7) / 8;
    localparam int SH_W      = POS_BYTES * 8;
    localparam int CNT_W     = 2;
    // One bit wider than the header field so a burst stepping past 63 is seen
    localparam int AX_W      = 7;

    state_e                 state_q, state_d;
    cmd_e                   cmd_q, cmd_d;
    logic [AX_W-1:0]        addr_q, addr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SH_W-1:0]        shift_q, shift_d;
    logic                   got_q, got_d;      // a word was committed in this frame
    logic [ADDR_W-1:0]      num_q, num_d;
    logic [POS_W-1:0]       pos_q, pos_d;
    logic                   all_q, all_d;
    logic                   new_pos_q, new_pos_d;
    logic                   frame_err_q, frame_err_d;
    logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;
`ifdef SPI_SERVO_CHECKSUM_EN
    logic [7:0]             hdr_q, hdr_d;
    logic [7:0]             csum_q, csum_d;
`endif

    logic [SH_W-1:0]        word_s;
    logic [SH_W-1:0]        cword_s;
    logic                   commit_s;
    logic                   err_s;

    // Bits above POS_W make the word larger than any legal position
    function automatic logic [POS_W-1:0] clamp_pos(input logic [SH_W-1:0] w);
        logic             over;
        logic [POS_W-1:0] raw;
        raw  = w[POS_W-1:0];
        over = |(w >> POS_W);
        if (over || (raw > POS_W'(POS_MAX))) begin
            return POS_W'(POS_MAX);
        end else begin
            return raw;
        end
    endfunction

    // Word as it stands once the current byte is shifted in (MSB first)
    assign word_s = SH_W'({shift_q, bus.spi_dout});

    // Next-state: byte handling first, then frame_end on the post-byte state
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        got_d       = got_q;
        num_d       = num_q;
        pos_d       = pos_q;
        all_d       = all_q;
        new_pos_d   = 1'b0;
        frame_err_d = 1'b0;
        err_count_d = err_count_q;
        commit_s    = 1'b0;
        cword_s     = shift_q;
        err_s       = 1'b0;
`ifdef SPI_SERVO_CHECKSUM_EN
        hdr_d       = hdr_q;
        csum_d      = csum_q;
`endif

        if (bus.frame_start) begin
            // Restart from any state; a word in flight is silently dropped
            state_d = HDR;
            cnt_d   = '0;
            shift_d = '0;
            got_d   = 1'b0;
        end else begin
            if (bus.spi_done) begin
                case (state_q)
                    HDR: begin
                        cmd_d   = cmd_e'(bus.spi_dout[HDR_CMD_MSB:HDR_CMD_LSB]);
                        addr_d  = AX_W'(bus.spi_dout[HDR_ADDR_MSB:HDR_ADDR_LSB]);
                        cnt_d   = '0;
                        shift_d = '0;
`ifdef SPI_SERVO_CHECKSUM_EN
                        hdr_d   = bus.spi_dout;
                        csum_d  = bus.spi_dout;
`endif
                        // Broadcast ignores the address field entirely
                        if (cmd_d == CMD_RSVD) begin
                            err_s   = 1'b1;
                            state_d = DISCARD;
                        end else if ((cmd_d != CMD_BCAST) && (32'(addr_d) >= 32'(NUM_CH))) begin
                            err_s   = 1'b1;
                            state_d = DISCARD;
                        end else begin
                            state_d = POS;
                        end
                    end
                    POS: begin
                        // Address only goes bad after a burst increment; the
                        // word it would address is dropped on its first byte
                        if ((cmd_q != CMD_BCAST) && (32'(addr_q) >= 32'(NUM_CH))) begin
                            err_s   = 1'b1;
                            state_d = DISCARD;
                        end else begin
                            shift_d = word_s;
`ifdef SPI_SERVO_CHECKSUM_EN
                            csum_d  = csum_add(csum_q, bus.spi_dout);
`endif
                            if (cnt_q == CNT_W'(POS_BYTES - 1)) begin
                                cnt_d = '0;
`ifdef SPI_SERVO_CHECKSUM_EN
                                state_d = CHK;
`else
                                commit_s = 1'b1;
                                cword_s  = word_s;
`endif
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end
                    end
`ifdef SPI_SERVO_CHECKSUM_EN
                    CHK: begin
                        if (csum_add(csum_q, bus.spi_dout) == 8'h00) begin
                            commit_s = 1'b1;
                        end else begin
                            err_s   = 1'b1;
                            state_d = DISCARD;
                        end
                    end
`endif
                    default: begin
                        // IDLE and DISCARD ignore bytes
                        state_d = state_q;
                    end
                endcase
            end else begin
                state_d = state_q;
            end

            if (commit_s) begin
                new_pos_d = 1'b1;
                all_d     = (cmd_q == CMD_BCAST);
                num_d     = (cmd_q == CMD_BCAST) ? '0 : addr_q[ADDR_W-1:0];
                pos_d     = clamp_pos(cword_s);
                got_d     = 1'b1;
                if (cmd_q == CMD_BURST) begin
                    addr_d  = addr_q + AX_W'(1);
                    state_d = POS;
                    shift_d = '0;
`ifdef SPI_SERVO_CHECKSUM_EN
                    csum_d  = hdr_q;
`endif
                end else begin
                    state_d = DISCARD;
                end
            end else begin
                new_pos_d = 1'b0;
            end

            // Partial word (or header with no word at all) at end of frame
            if (bus.frame_end) begin
                if (((state_d == POS) && ((cnt_d != '0) || !got_d)) || (state_d == CHK)) begin
                    err_s = 1'b1;
                end else begin
                    err_s = err_s;
                end
                state_d = IDLE;
            end else begin
                state_d = state_d;
            end
        end

        frame_err_d = err_s;
        if (err_s && (err_count_q != '1)) begin
            err_count_d = err_count_q + ERR_CNT_W'(1);
        end else begin
            err_count_d = err_count_q;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cmd_q       <= CMD_SINGLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            shift_q     <= '0;
            got_q       <= 1'b0;
            num_q       <= '0;
            pos_q       <= '0;
            all_q       <= 1'b0;
            new_pos_q   <= 1'b0;
            frame_err_q <= 1'b0;
            err_count_q <= '0;
`ifdef SPI_SERVO_CHECKSUM_EN
            hdr_q       <= 8'h00;
            csum_q      <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            got_q       <= got_d;
            num_q       <= num_d;
            pos_q       <= pos_d;
            all_q       <= all_d;
            new_pos_q   <= new_pos_d;
            frame_err_q <= frame_err_d;
            err_count_q <= err_count_d;
`ifdef SPI_SERVO_CHECKSUM_EN
            hdr_q       <= hdr_d;
            csum_q      <= csum_d;
`endif
        end
    end

    assign bus.servo_num = num_q;
    assign bus.servo_pos = pos_q;
    assign bus.servo_all = all_q;
    assign bus.new_pos   = new_pos_q;
    assign bus.frame_err = frame_err_q;
    assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_spi_servo_cmd_decoder.sv
// Self-checking bench for spi_servo_cmd_decoder. Two instances share one
// stimulus stream: dut_a with default clamp (4095) and 8-bit error counter,
// dut_b with POS_MAX=2000 and a 3-bit error counter. A frame-level model
// derives the expected servo bus from the bytes seen in the current frame.
module tb_spi_servo_cmd_decoder;
    localparam int NUM_CH    = 32;
    localparam int POS_BYTES = 2;
`ifdef SPI_SERVO_CHECKSUM_EN
    localparam int WB = POS_BYTES + 1;
`else
    localparam int WB = POS_BYTES;
`endif
    localparam int MAX_A  = 4095;
    localparam int MAX_B  = 2000;
    localparam int CSAT_A = 255;
    localparam int CSAT_B = 7;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spi_servo_cmd_decoder_if #(.ADDR_W(5), .POS_W(12), .ERR_CNT_W(8)) bus_a ();
    spi_servo_cmd_decoder_if #(.ADDR_W(5), .POS_W(12), .ERR_CNT_W(3)) bus_b ();

    spi_servo_cmd_decoder #(.NUM_CH(NUM_CH), .POS_W(12), .POS_MAX(MAX_A), .ERR_CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
    spi_servo_cmd_decoder #(.NUM_CH(NUM_CH), .POS_W(12), .POS_MAX(MAX_B), .ERR_CNT_W(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

    int n_checks = 0;
    int n_fail   = 0;

    // Frame-level model state
    bit         frame_open = 1'b0;
    bit         dead       = 1'b0;
    logic [7:0] fb[$];
    int         m_cmd = 0, m_start = 0;
    int         m_commits = 0, dut_commits = 0;

    // nx_*: outputs after the coming edge; ex_*: outputs now visible
    int nx_num = 0, nx_pos_a = 0, nx_pos_b = 0, nx_cnt_a = 0, nx_cnt_b = 0;
    bit nx_all = 0, nx_new = 0, nx_err = 0;
    int ex_num = 0, ex_pos_a = 0, ex_pos_b = 0, ex_cnt_a = 0, ex_cnt_b = 0;
    bit ex_all = 0, ex_new = 0, ex_err = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, req, req, $time);
        end
    endtask

    task automatic m_err();
        if (!nx_err) begin
            nx_err = 1'b1;
            if (nx_cnt_a < CSAT_A) nx_cnt_a++;
            if (nx_cnt_b < CSAT_B) nx_cnt_b++;
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        int n, j, k, off, addr, val, base;
        logic [7:0] x;
        if (!frame_open) return;
        fb.push_back(b);
        n = fb.size();
        if (n == 1) begin
            m_cmd   = int'(b[7:6]);
            m_start = int'(b[5:0]);
            if (m_cmd == 3 || (m_cmd != 2 && m_start >= NUM_CH)) begin
                m_err();
                dead = 1'b1;
            end
            return;
        end
        if (dead) return;
        j    = n - 2;
        k    = j / WB;
        off  = j % WB;
        addr = m_start + k;
        if (m_cmd != 2 && addr >= NUM_CH) begin
            m_err();
            dead = 1'b1;
            return;
        end
        if (off == WB - 1) begin
            base = 1 + k * WB;
            val  = 0;
            for (int i = 0; i < POS_BYTES; i++) val = val * 256 + int'(fb[base + i]);
`ifdef SPI_SERVO_CHECKSUM_EN
            x = fb[0];
            for (int i = 0; i < WB; i++) x = x ^ fb[base + i];
            if (x != 8'h00) begin
                m_err();
                dead = 1'b1;
                return;
            end
`else
            x = 8'h00;
`endif
            nx_new   = 1'b1;
            nx_all   = (m_cmd == 2);
            nx_num   = (m_cmd == 2) ? 0 : addr;
            nx_pos_a = (val > MAX_A) ? MAX_A : val;
            nx_pos_b = (val > MAX_B) ? MAX_B : val;
            m_commits++;
            if (m_cmd != 1) dead = 1'b1;
        end
    endtask

    task automatic model_end();
        int n;
        if (frame_open && !dead) begin
            n = fb.size();
            if (n == 1 || (n > 1 && ((n - 1) % WB) != 0)) m_err();
        end
        frame_open = 1'b0;
    endtask

    // One clock: drive inputs, advance the model, wait past the edge
    task automatic step(input bit rst, input bit fs, input bit sd, input logic [7:0] b, input bit fe);
        rst_n             = !rst;
        bus_a.frame_start = fs; bus_b.frame_start = fs;
        bus_a.spi_done    = sd; bus_b.spi_done    = sd;
        bus_a.spi_dout    = b;  bus_b.spi_dout    = b;
        bus_a.frame_end   = fe; bus_b.frame_end   = fe;
        nx_new = 1'b0;
        nx_err = 1'b0;
        if (rst) begin
            nx_num = 0; nx_pos_a = 0; nx_pos_b = 0; nx_all = 0;
            nx_cnt_a = 0; nx_cnt_b = 0;
            frame_open = 1'b0;
        end else begin
            if (fs) begin
                frame_open = 1'b1;
                dead = 1'b0;
                fb.delete();
            end
            if (sd) model_byte(b);
            if (fe) model_end();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic send_b(input logic [7:0] b, input int maxgap);
        step(1'b0, 1'b0, 1'b1, b, 1'b0);
        idle($urandom_range(0, maxgap));
    endtask

    task automatic start_f();
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic end_f();
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic send_word(input logic [7:0] hdr, input logic [15:0] w);
        send_b(w[15:8], 1);
        send_b(w[7:0], 1);
`ifdef SPI_SERVO_CHECKSUM_EN
        send_b(hdr ^ w[15:8] ^ w[7:0], 1);
`else
        if (hdr == 8'hFF) idle(0);
`endif
    endtask

    always @(posedge clk) begin
        ex_num <= nx_num; ex_pos_a <= nx_pos_a; ex_pos_b <= nx_pos_b;
        ex_all <= nx_all; ex_new <= nx_new; ex_err <= nx_err;
        ex_cnt_a <= nx_cnt_a; ex_cnt_b <= nx_cnt_b;
    end

    // Compare both instances against the model on every cycle
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("servo_num_a", int'(bus_a.servo_num), ex_num);
            chk("servo_pos_a", int'(bus_a.servo_pos), ex_pos_a);
            chk("servo_all_a", int'(bus_a.servo_all), int'(ex_all));
            chk("new_pos_a",   int'(bus_a.new_pos),   int'(ex_new));
            chk("frame_err_a", int'(bus_a.frame_err), int'(ex_err));
            chk("err_count_a", int'(bus_a.err_count), ex_cnt_a);
            chk("servo_num_b", int'(bus_b.servo_num), ex_num);
            chk("servo_pos_b", int'(bus_b.servo_pos), ex_pos_b);
            chk("servo_all_b", int'(bus_b.servo_all), int'(ex_all));
            chk("new_pos_b",   int'(bus_b.new_pos),   int'(ex_new));
            chk("frame_err_b", int'(bus_b.frame_err), int'(ex_err));
            chk("err_count_b", int'(bus_b.err_count), ex_cnt_b);
            if (bus_a.new_pos) dut_commits++;
        end
    end

    initial begin
        int c0, d0, r, nw, cmd, addr, mode, cut;
        logic [7:0]  hb, c;
        logic [15:0] w;
        logic [7:0]  fr[$];

        rst_n = 1'b0;
        bus_a.frame_start = 1'b0; bus_a.spi_done = 1'b0; bus_a.spi_dout = 8'h00; bus_a.frame_end = 1'b0;
        bus_b.frame_start = 1'b0; bus_b.spi_done = 1'b0; bus_b.spi_dout = 8'h00; bus_b.frame_end = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        cmp_en = 1'b1;
        idle(2);
        chk("reset_pos",   int'(bus_a.servo_pos), 0);
        chk("reset_num",   int'(bus_a.servo_num), 0);
        chk("reset_count", int'(bus_a.err_count), 0);

        // SINGLE ch5 = 0x123
        c0 = m_commits; d0 = dut_commits;
        start_f(); send_b(8'h05, 1); send_word(8'h05, 16'h0123); end_f(); idle(2);
        chk("single_commits", m_commits - c0, 1);
        chk("single_dut_commits", dut_commits - d0, 1);
        chk("single_num", ex_num, 5);
        chk("single_pos", ex_pos_a, 12'h123);
        chk("single_all", int'(ex_all), 0);
        chk("single_errcnt", ex_cnt_a, 0);

        // BURST from ch30: 0x100, 0xFFF, third word runs past the last channel
        c0 = m_commits;
        start_f(); send_b(8'h5E, 0);
        send_word(8'h5E, 16'h0100); idle(1);
        chk("burst_w0_num", ex_num, 30);
        chk("burst_w0_pos", ex_pos_a, 12'h100);
        send_word(8'h5E, 16'h0FFF); idle(1);
        chk("burst_w1_num", ex_num, 31);
        chk("burst_w1_pos_a", ex_pos_a, 12'hFFF);
        chk("burst_w1_pos_b", ex_pos_b, 2000);
        send_word(8'h5E, 16'h1234); end_f(); idle(2);
        chk("burst_errcnt", ex_cnt_a, 1);
        chk("burst_commits", m_commits - c0, 2);
        chk("burst_dut_errcnt", int'(bus_a.err_count), 1);

        // BCAST 0xABC with trailing junk
        c0 = m_commits;
        start_f(); send_b(8'h80, 0); send_word(8'h80, 16'h0ABC);
        send_b(8'h11, 0); send_b(8'h22, 0); end_f(); idle(2);
        chk("bcast_all", int'(ex_all), 1);
        chk("bcast_num", ex_num, 0);
        chk("bcast_pos_a", ex_pos_a, 12'hABC);
        chk("bcast_pos_b", ex_pos_b, 2000);
        chk("bcast_commits", m_commits - c0, 1);
        chk("bcast_errcnt", ex_cnt_a, 1);

        // Clamp on the 2000 instance, then a reserved command
        start_f(); send_b(8'h02, 0); send_word(8'h02, 16'h0FA0); end_f(); idle(1);
        chk("clamp_pos_b", ex_pos_b, 2000);
        chk("clamp_pos_a", ex_pos_a, 12'hFA0);
        c0 = m_commits;
        start_f(); send_b(8'hC0, 0); send_b(8'h01, 0); send_b(8'h23, 0); end_f(); idle(2);
        chk("rsvd_commits", m_commits - c0, 0);
        chk("rsvd_errcnt", ex_cnt_a, 2);

        // Partial word at frame end
        c0 = m_commits;
        start_f(); send_b(8'h04, 0); send_b(8'h01, 0); end_f(); idle(2);
        chk("partial_commits", m_commits - c0, 0);
        chk("partial_errcnt", ex_cnt_a, 3);

        // Reset mid-word, then a clean frame
        start_f(); send_b(8'h06, 0); send_b(8'h01, 0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("midrst_pos", int'(bus_a.servo_pos), 0);
        chk("midrst_count", int'(bus_a.err_count), 0);
        start_f(); send_b(8'h06, 0); send_word(8'h06, 16'h0777); end_f(); idle(2);
        chk("after_rst_num", ex_num, 6);
        chk("after_rst_pos", ex_pos_a, 12'h777);

`ifdef SPI_SERVO_CHECKSUM_EN
        start_f(); send_b(8'h03, 0); send_b(8'h01, 0); send_b(8'h23, 0); send_b(8'h21, 0); end_f(); idle(2);
        chk("csum_ok_num", ex_num, 3);
        chk("csum_ok_pos", ex_pos_a, 12'h123);
        c0 = m_commits;
        start_f(); send_b(8'h03, 0); send_b(8'h01, 0); send_b(8'h23, 0); send_b(8'h20, 0); end_f(); idle(2);
        chk("csum_bad_commits", m_commits - c0, 0);
        chk("csum_bad_errcnt", ex_cnt_a, 1);
`endif

        // Randomized frames
        for (int f = 0; f < 300; f++) begin
            fr.delete();
            r    = $urandom_range(0, 9);
            cmd  = (r < 4) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : 3;
            r    = $urandom_range(0, 9);
            addr = (r < 5) ? $urandom_range(26, 31) : (r < 7) ? $urandom_range(32, 63) : $urandom_range(0, 25);
            hb   = {2'(cmd), 6'(addr)};
            fr.push_back(hb);
            nw = $urandom_range(0, 4);
            for (int i = 0; i < nw; i++) begin
                r = $urandom_range(0, 5);
                case (r)
                    0:       w = 16'($urandom_range(0, 1999));
                    1:       w = 16'($urandom_range(2000, 4095));
                    2:       w = 16'($urandom);
                    3:       w = 16'd2000;
                    4:       w = 16'd2001;
                    default: w = ($urandom_range(0, 1) == 0) ? 16'd4095 : 16'd4096;
                endcase
                fr.push_back(w[15:8]);
                fr.push_back(w[7:0]);
`ifdef SPI_SERVO_CHECKSUM_EN
                c = hb ^ w[15:8] ^ w[7:0];
                if ($urandom_range(0, 6) == 0) c = c ^ 8'h01;
                fr.push_back(c);
`else
                c = 8'h00;
`endif
            end
            if ($urandom_range(0, 3) == 0) begin
                cut = $urandom_range(1, 2);
                for (int i = 0; i < cut; i++) if (fr.size() > 0) void'(fr.pop_back());
            end
            if ($urandom_range(0, 9) == 0) send_b(8'($urandom), 0);
            mode = $urandom_range(0, 19);
            start_f();
            idle($urandom_range(0, 1));
            if (mode == 0) begin
                for (int i = 0; i < fr.size() / 2; i++) send_b(fr[i], 2);
                step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
            end else begin
                for (int i = 0; i < fr.size(); i++) begin
                    if (i == fr.size() - 1 && mode >= 2 && mode <= 6)
                        step(1'b0, 1'b0, 1'b1, fr[i], 1'b1);
                    else
                        send_b(fr[i], 2);
                end
                if (mode == 1) idle(0);
                else if (mode > 6 || fr.size() == 0) end_f();
            end
            idle($urandom_range(0, 2));
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
